// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: 2-flop synchronized RX, 16x oversampling, single-entry
// valid/ready byte output with one-cycle framing-error and overrun pulses.
module uart_rx_deserializer #(
  parameter int CLK_FREQ_HZ = 80000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int DIVISOR = (CLK_FREQ_HZ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int PW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIVISOR - 1);

  if (DIVISOR < 1) begin : g_divisor_check
    $error("uart_rx_deserializer: DIVISOR must be at least 1");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          rx_meta_q, rx_s_q;
  logic [2:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    os_q, os_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          tick;
  logic          complete;

  assign tick = (presc_q == PRESC_MAX);

  always_comb begin
    state_d  = state_q;
    presc_d  = tick ? '0 : presc_q + PW'(1);
    os_d     = tick ? os_q + 4'd1 : os_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    complete = 1'b0;

    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        os_d    = 4'd0;
        bit_d   = 3'd0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        // Mid-start-bit check; a high level here means the edge was a glitch.
        if (tick && os_q == 4'd7) begin
          if (!rx_s_q) begin
            state_d = S_DATA;
            os_d    = 4'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick && os_q == 4'd15) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick && os_q == 4'd15) begin
          if (rx_s_q) begin
            complete = 1'b1;
            state_d  = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        presc_d = '0;
        os_d    = 4'd0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (valid_q && i_ready) valid_d = 1'b0;
    // A byte landing in the same cycle as a drain replaces the old one.
    if (complete) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      presc_q   <= '0;
      os_q      <= 4'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= i_uart_rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      presc_q   <= presc_d;
      os_q      <= os_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at DIVISOR 4 (64-cycle bits);
// delivered bytes are checked against a queue of expected bytes.
module tb_uart_rx_deserializer;

  localparam int BIT = 64;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_uart_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;

  int vectors     = 0;
  int miscompares = 0;
  int n_deliv     = 0;
  int n_ferr      = 0;
  int n_ovr       = 0;
  logic [7:0] exp_q[$];

  uart_rx_deserializer #(
    .CLK_FREQ_HZ(6400000),
    .BAUD_RATE  (100000)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_uart_rx  (i_uart_rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Drives the first nsym symbols of an 8N1 frame: start, 8 data LSB-first, stop.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int nsym);
    logic [9:0] sym;
    sym = {stop, b, 1'b0};
    for (int i = 0; i < nsym; i++) begin
      i_uart_rx = sym[i];
      cyc(BIT);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_frame_err) n_ferr++;
    if (o_overrun) n_ovr++;
    if (o_valid && i_ready) begin
      n_deliv++;
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {24'd0, o_data}, 32'hFFFF_FFFF);
      end else begin
        check("rx_data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    i_rst_n   = 1'b0;
    i_uart_rx = 1'b1;
    i_ready   = 1'b1;
    cyc(5);
    check("reset_data", {24'd0, o_data}, 32'd0);
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_ferr", {31'd0, o_frame_err}, 32'd0);
    check("reset_ovr", {31'd0, o_overrun}, 32'd0);
    i_rst_n = 1'b1;
    cyc(BIT);

    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 10);
    cyc(16);
    check("single_deliv", n_deliv, 1);
    check("single_valid_low", {31'd0, o_valid}, 32'd0);
    check("single_ferr", n_ferr, 0);
    check("single_ovr", n_ovr, 0);

    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    send_frame(8'h00, 1'b1, 10);
    send_frame(8'hFF, 1'b1, 10);
    send_frame(8'h55, 1'b1, 10);
    cyc(16);
    check("b2b_deliv", n_deliv, 4);
    check("b2b_queue_empty", exp_q.size(), 0);

    i_ready = 1'b0;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 10);
    send_frame(8'h34, 1'b1, 10);
    cyc(16);
    check("ovr_valid_held", {31'd0, o_valid}, 32'd1);
    check("ovr_data_kept", {24'd0, o_data}, 32'h12);
    check("ovr_pulse", n_ovr, 1);
    i_ready = 1'b1;
    cyc(4);
    check("ovr_valid_drop", {31'd0, o_valid}, 32'd0);
    check("ovr_deliv", n_deliv, 5);
    check("ovr_queue_empty", exp_q.size(), 0);

    send_frame(8'h99, 1'b0, 10);
    cyc(3 * BIT);
    i_uart_rx = 1'b1;
    cyc(2 * BIT);
    check("ferr_pulse", n_ferr, 1);
    check("ferr_valid", {31'd0, o_valid}, 32'd0);
    check("ferr_deliv", n_deliv, 5);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 10);
    cyc(16);
    check("after_break_deliv", n_deliv, 6);

    i_uart_rx = 1'b0;
    cyc(16);
    i_uart_rx = 1'b1;
    cyc(2 * BIT);
    check("glitch_deliv", n_deliv, 6);
    check("glitch_ferr", n_ferr, 1);
    check("glitch_ovr", n_ovr, 1);

    send_frame(8'hC3, 1'b1, 5);
    i_uart_rx = 1'b0;
    cyc(20);
    i_rst_n = 1'b0;
    cyc(2);
    check("midrst_data", {24'd0, o_data}, 32'd0);
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_ferr", {31'd0, o_frame_err}, 32'd0);
    check("midrst_ovr", {31'd0, o_overrun}, 32'd0);
    i_uart_rx = 1'b1;
    cyc(50);
    i_rst_n = 1'b1;
    cyc(BIT);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 10);
    cyc(16);
    check("post_rst_deliv", n_deliv, 7);
    check("post_rst_queue_empty", exp_q.size(), 0);
    check("final_ferr", n_ferr, 1);
    check("final_ovr", n_ovr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
